seg_capture: RTL and testbench

SEG_CAPTURE -- requirements
Module: seg_capture

---
 rtl/seg_pkg.sv | 19 +
 rtl/seg_decode.sv | 23 ++
 rtl/seg_capture.sv | 229 ++++++++++++++++++++++
 tb/tb_seg_capture.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment capture block.
// Holds the reverse-decode pattern table and the digit index type.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] ANODE_BLANK = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  // Active-low segment patterns for hex 0..F, dp bit held at 1
  localparam logic [7:0] SEG_PAT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/seg_decode.sv
// Reverse decoder: 7-bit active-low segment pattern to hex code.
// Unknown patterns report o_legal = 0 and code 0.
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic       o_legal,
  output logic [3:0] o_code
);

  // Search the pattern table for a match
  always_comb begin
    o_legal = 1'b0;
    o_code  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (i_pat == SEG_PAT[i][6:0]) begin
        o_legal = 1'b1;
        o_code  = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg_capture.sv
// Captures hex digits from a multiplexed seven-segment display bus.
// Optional macro SEG_CAPTURE_DP_EN adds the dp_out decimal-point port.
module seg_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 262144
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] anode,
  input  logic [7:0] cathode,
  output logic [3:0] code0,
  output logic [3:0] code1,
  output logic [3:0] code2,
  output logic [3:0] code3,
  output logic [3:0] digit_valid,
  output logic       update,
  output logic       frame_done,
  output logic       err_illegal
`ifdef SEG_CAPTURE_DP_EN
  ,
  output logic [3:0] dp_out
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] STABLE_MAX =
    8'(STABLE_CYCLES);

  localparam logic [TW-1:0] TO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  localparam logic [TW-1:0] TO_MAX =
    TW'(TIMEOUT_CYCLES);

  logic [11:0] r_sync1;
  logic [11:0] r_sync2;
  logic [11:0] r_prev;
  logic [7:0]  r_cnt;
  logic        r_done;

  logic [3:0][3:0]    r_code;
  logic [3:0]         r_valid;
  logic [3:0]         r_seen;
  logic               r_err;
  logic               r_update;
  logic               r_frame;
  logic [3:0][TW-1:0] r_to;

  logic             w_same;
  logic             w_eval;
  logic             w_legal;
  logic [3:0]       w_dcode;
  logic             w_one;
  logic             w_multi;
  digit_idx_t       w_idx;
  logic [3:0][3:0]  w_code_nxt;
  logic [3:0]       w_valid_nxt;
  logic [3:0]       w_seen_nxt;
  logic             w_err_nxt;
  logic [3:0]       w_acc;
  logic             w_frame;
  logic             w_chg;

`ifdef SEG_CAPTURE_DP_EN
  logic [3:0] r_dp;
  logic [3:0] w_dp_nxt;
`endif

  assign w_same = (r_sync2 == r_prev);
  assign w_eval = (r_cnt == STABLE_MAX) && !r_done;

  seg_decode u_dec (
    .i_pat   (r_prev[6:0]),
    .o_legal (w_legal),
    .o_code  (w_dcode)
  );

  // Which digit the held sample selects
  always_comb begin
    w_one   = 1'b0;
    w_multi = 1'b0;
    w_idx   = '0;
    unique case (1'b1)
      (r_prev[11:8] == 4'b1110): begin
        w_one = 1'b1;
        w_idx = 2'd0;
      end
      (r_prev[11:8] == 4'b1101): begin
        w_one = 1'b1;
        w_idx = 2'd1;
      end
      (r_prev[11:8] == 4'b1011): begin
        w_one = 1'b1;
        w_idx = 2'd2;
      end
      (r_prev[11:8] == 4'b0111): begin
        w_one = 1'b1;
        w_idx = 2'd3;
      end
      (r_prev[11:8] == ANODE_BLANK): ;
      default: w_multi = 1'b1;
    endcase
  end

  // Next digit state: timeouts first, acceptance overrides
  always_comb begin
    w_code_nxt  = r_code;
    w_valid_nxt = r_valid;
    w_seen_nxt  = r_seen;
    w_err_nxt   = r_err;
    w_acc       = '0;
`ifdef SEG_CAPTURE_DP_EN
    w_dp_nxt    = r_dp;
`endif
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (r_to[n] == TO_LAST) begin
        w_valid_nxt[n] = 1'b0;
      end
    end
    if (w_eval) begin
      if (w_one && w_legal) begin
        w_code_nxt[w_idx]  = w_dcode;
        w_valid_nxt[w_idx] = 1'b1;
        w_seen_nxt[w_idx]  = 1'b1;
        w_acc[w_idx]       = 1'b1;
`ifdef SEG_CAPTURE_DP_EN
        w_dp_nxt[w_idx]    = ~r_prev[7];
`endif
      end else if (w_one) begin
        w_valid_nxt[w_idx] = 1'b0;
        w_err_nxt          = 1'b1;
      end else if (w_multi) begin
        w_err_nxt = 1'b1;
      end
    end
    w_frame = (w_seen_nxt == 4'hF);
    w_chg   = (w_code_nxt != r_code) ||
              (w_valid_nxt != r_valid);
`ifdef SEG_CAPTURE_DP_EN
    w_chg   = w_chg || (w_dp_nxt != r_dp);
`endif
  end

  // Synchronizer and stability counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_sync1 <= {anode, cathode};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (!w_same) begin
        r_cnt  <= 8'd1;
        r_done <= 1'b0;
      end else begin
        if (r_cnt != STABLE_MAX) begin
          r_cnt <= r_cnt + 8'd1;
        end
        if (w_eval) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  // Registered digit state and pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code   <= '0;
      r_valid  <= '0;
      r_seen   <= '0;
      r_err    <= 1'b0;
      r_update <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      r_code   <= w_code_nxt;
      r_valid  <= w_valid_nxt;
      r_seen   <= w_frame ? 4'h0 : w_seen_nxt;
      r_err    <= w_err_nxt;
      r_update <= w_chg;
      r_frame  <= w_frame;
    end
  end

  // Per-digit timeout counters, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to <= '0;
    end else begin
      for (int n = 0; n < NUM_DIGITS; n++) begin
        if (w_acc[n]) begin
          r_to[n] <= '0;
        end else if (r_to[n] != TO_MAX) begin
          r_to[n] <= r_to[n] + TW'(1);
        end
      end
    end
  end

`ifdef SEG_CAPTURE_DP_EN
  // Decimal point of each accepted digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp <= '0;
    end else begin
      r_dp <= w_dp_nxt;
    end
  end

  assign dp_out = r_dp;
`endif

  assign code0       = r_code[0];
  assign code1       = r_code[1];
  assign code2       = r_code[2];
  assign code3       = r_code[3];
  assign digit_valid = r_valid;
  assign update      = r_update;
  assign frame_done  = r_frame;
  assign err_illegal = r_err;

endmodule

// File: tb/tb_seg_capture.sv
// Directed testbench for seg_capture.
// Timeout shortened to keep the run brief.
module tb_seg_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] anode = 4'hF;
  logic [7:0] cathode = 8'hFF;
  logic [3:0] code0, code1, code2, code3;
  logic [3:0] digit_valid;
  logic       update;
  logic       frame_done;
  logic       err_illegal;
`ifdef SEG_CAPTURE_DP_EN
  logic [3:0] dp_out;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int upd_cnt  = 0;
  int upd_at   = 0;
  int frm_cnt  = 0;

  logic [3:0] an_t [4] = '{4'b0111, 4'b1011,
                           4'b1101, 4'b1110};
  logic [7:0] ca_t [4] = '{8'hB0, 8'h99,
                           8'h88, 8'hC0};

  seg_capture #(
    .STABLE_CYCLES  (16),
    .TIMEOUT_CYCLES (300)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .anode       (anode),
    .cathode     (cathode),
    .code0       (code0),
    .code1       (code1),
    .code2       (code2),
    .code3       (code3),
    .digit_valid (digit_valid),
    .update      (update),
    .frame_done  (frame_done),
    .err_illegal (err_illegal)
`ifdef SEG_CAPTURE_DP_EN
    ,
    .dp_out      (dp_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic clr();
    cyc     = 0;
    upd_cnt = 0;
    upd_at  = 0;
    frm_cnt = 0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (update) begin
        upd_cnt++;
        upd_at = cyc;
      end
      if (frame_done) frm_cnt++;
    end
  endtask

  task automatic drive(input logic [3:0] a,
                       input logic [7:0] c);
    anode   = a;
    cathode = c;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #22;
    check("rst_codes", {code3, code2, code1, code0}, 0);
    check("rst_valid", digit_valid, 0);
    check("rst_update", update, 0);
    check("rst_frame", frame_done, 0);
    check("rst_err", err_illegal, 0);
    rst_n = 1'b1;
    run(25);

    // single digit 0 = "2", latency 19
    drive(4'b1110, 8'hA4);
    clr();
    run(18);
    check("lat_early_code0", code0, 0);
    run(2);
    check("lat_code0", code0, 2);
    check("lat_valid", digit_valid, 4'b0001);
    check("lat_upd_cnt", upd_cnt, 1);
    check("lat_upd_at", upd_at, 19);

    // two full rotations over all digits
    for (int r = 0; r < 2; r++) begin
      clr();
      for (int s = 0; s < 4; s++) begin
        drive(an_t[s], ca_t[s]);
        run(25);
      end
      check("rot_frames", frm_cnt, 1);
      check("rot_updates", upd_cnt, (r == 0) ? 4 : 0);
    end
    check("rot_codes", {code3, code2, code1, code0},
          16'h34A0);
    check("rot_valid", digit_valid, 4'hF);
    check("rot_err", err_illegal, 0);

    // glitching cathode never settles long enough
    clr();
    for (int g = 0; g < 8; g++) begin
      drive(4'b1011, g[0] ? 8'h80 : 8'h90);
      run(8);
    end
    check("glitch_upd", upd_cnt, 0);
    check("glitch_codes", {code3, code2, code1, code0},
          16'h34A0);
    check("glitch_valid", digit_valid, 4'hF);

    // blank segments on digit 1 are illegal
    clr();
    drive(4'b1101, 8'hFF);
    run(25);
    check("ill_err", err_illegal, 1);
    check("ill_valid", digit_valid, 4'b1101);
    check("ill_code1", code1, 4'hA);
    check("ill_upd", upd_cnt, 1);

    // two anodes low: error only
    clr();
    drive(4'b0011, 8'hC0);
    run(25);
    check("multi_valid", digit_valid, 4'b1101);
    check("multi_codes", {code3, code2, code1, code0},
          16'h34A0);
    check("multi_upd", upd_cnt, 0);
    check("multi_err", err_illegal, 1);

    // digit 2 = "6" then blank until it times out
    clr();
    drive(4'b1011, 8'h82);
    run(19);
    check("to_acc_code2", code2, 6);
    check("to_acc_valid2", digit_valid[2], 1);
    drive(4'hF, 8'hFF);
    run(299);
    check("to_early_valid2", digit_valid[2], 1);
    run(1);
    check("to_valid2", digit_valid[2], 0);
    check("to_update", update, 1);
    check("to_code2_hold", code2, 6);
    check("to_all_valid", digit_valid, 0);

    // reset while the counter sits at 10
    drive(4'b1110, 8'hF9);
    run(12);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_codes", {code3, code2, code1, code0},
          0);
    check("mid_rst_valid", digit_valid, 0);
    check("mid_rst_err", err_illegal, 0);
    check("mid_rst_update", update, 0);
    #2 rst_n = 1'b1;
    clr();
    run(18);
    check("rel_early_code0", code0, 0);
    run(1);
    check("rel_code0", code0, 1);
    check("rel_valid", digit_valid, 4'b0001);
    check("rel_update", update, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
